// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, default base, response payload.
package dmem_pkg;

    localparam logic [1:0]  SIZE_BYTE         = 2'b00;
    localparam logic [1:0]  SIZE_HALF         = 2'b01;
    localparam logic [1:0]  SIZE_WORD         = 2'b10;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    // Byte enables for an access of the given size at the given byte lane.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: byte_en = 4'b0001 << lane;
            SIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default:   byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  rsp_t                         push_data,
    input  logic                         pop,
    output rsp_t                         head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    rsp_t          entries [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        next_ptr = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = entries[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency, in-order load/store responses with a credit-limited buffer.
// Define DMEM_ERR_CHECK_EN to fault misaligned and out-of-range accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH     = 16384,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic [31:0]   storage [DEPTH];
    logic [CW-1:0] occ;
    logic          accept;
    logic          pop;
    logic          rsp_present;

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic [1:0]    size_eff;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   rd_word;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic          fault;
    rsp_t          in_rsp;

    rsp_t          push_rsp;
    logic          push_valid;
    rsp_t          head;
    logic          fifo_empty;
    logic [CW-1:0] unused_count;
    logic          unused_full;
    logic          unused_bits;

    // Credit: in-flight plus buffered responses never exceed the buffer size.
    assign req_ready   = ~reset & (occ < CW'(RSP_DEPTH));
    assign accept      = req_valid & req_ready;
    assign rsp_present = ~reset & ~fifo_empty;
    assign pop         = rsp_present & rsp_ready;
    assign rsp_valid   = rsp_present;
    assign rsp_rdata   = rsp_present ? head.rdata : '0;
    assign rsp_err     = rsp_present & head.err;
    assign unused_bits = ^{offset[31:AW+2], offset[1:0]};

    always_comb begin
        offset   = req_addr - BASE_ADDR;
        word_idx = offset[AW+1:2];
        size_eff = (req_size == 2'b11) ? SIZE_WORD : req_size;
        fault    = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        fault = (req_addr < BASE_ADDR)
              | (offset >= 32'(4 * DEPTH))
              | (req_size == 2'b11)
              | ((req_size == SIZE_HALF) & req_addr[0])
              | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00));
`endif
        // Misaligned half/word accesses are aligned down to their natural lane.
        case (size_eff)
            SIZE_BYTE: lane = req_addr[1:0];
            SIZE_HALF: lane = {req_addr[1], 1'b0};
            default:   lane = 2'b00;
        endcase
        be = byte_en(size_eff, lane);
        case (size_eff)
            SIZE_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SIZE_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default:   wdata_rep = req_wdata;
        endcase
        rd_word = storage[word_idx];
        shifted = rd_word >> {lane, 3'b000};
        case (size_eff)
            SIZE_BYTE: load_data = {24'b0, shifted[7:0]};
            SIZE_HALF: load_data = {16'b0, shifted[15:0]};
            default:   load_data = shifted;
        endcase
        if (req_write | fault) load_data = '0;
        in_rsp.err   = fault;
        in_rsp.rdata = load_data;
    end

    // Storage survives reset; stores commit on the accept edge.
    always_ff @(posedge clock) begin
        if (accept & req_write & ~fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) storage[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // The buffer write is the final pipe stage, so LATENCY-1 register stages precede it.
    if (LATENCY == 1) begin : g_direct
        assign push_valid = accept;
        assign push_rsp   = in_rsp;
    end else begin : g_pipe
        logic [LATENCY-2:0] pipe_v;
        rsp_t               pipe_d [LATENCY-1];

        always_ff @(posedge clock) begin
            if (reset) begin
                pipe_v <= '0;
            end else begin
                pipe_v[0] <= accept;
                for (int i = 1; i < int'(LATENCY) - 1; i++) pipe_v[i] <= pipe_v[i-1];
            end
        end

        always_ff @(posedge clock) begin
            pipe_d[0] <= in_rsp;
            for (int i = 1; i < int'(LATENCY) - 1; i++) pipe_d[i] <= pipe_d[i-1];
        end

        assign push_valid = pipe_v[LATENCY-2];
        assign push_rsp   = pipe_d[LATENCY-2];
    end

    dmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_rsp),
        .pop       (pop),
        .head      (head),
        .count     (unused_count),
        .empty     (fifo_empty),
        .full      (unused_full)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters, LATENCY=1, RSP_DEPTH=4).
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int unsigned DEPTH = 16384;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clock = ~clock;

    dmem_responder dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One isolated transaction with rsp_ready held high; called at a negedge, returns at a negedge.
    task automatic xact(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                        input string tag);
        int n;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int got;
        int pops;
        int last;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = BASE;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clock);

        // Store word, then load the top byte; response one cycle after each accept.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = BASE; req_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("t1_st_valid", 32'(rsp_valid), 32'd1);
        chk("t1_st_rdata", rsp_rdata, 32'd0);
        req_write = 1'b0; req_size = 2'b00; req_addr = BASE + 32'd3;
        @(negedge clock);
        chk("t1_ldb_valid", 32'(rsp_valid), 32'd1);
        chk("t1_ldb_rdata", rsp_rdata, 32'h0000_00DE);
        // Half store back-to-back with a word load of the same word.
        req_write = 1'b1; req_size = 2'b01; req_addr = BASE + 32'd2; req_wdata = 32'hAAAA_1234;
        @(negedge clock);
        chk("t2_st_rdata", rsp_rdata, 32'd0);
        req_write = 1'b0; req_size = 2'b10; req_addr = BASE;
        @(negedge clock);
        chk("t2_raw_valid", 32'(rsp_valid), 32'd1);
        chk("t2_raw_rdata", rsp_rdata, 32'h1234_BEEF);
        req_valid = 1'b0;
        @(negedge clock);
        chk("t2_idle", 32'(rsp_valid), 32'd0);

        xact(1'b0, 2'b01, BASE + 32'd2, 32'd0, 32'h0000_1234, 1'b0, "ld_half_hi");
        xact(1'b0, 2'b00, BASE + 32'd1, 32'd0, 32'h0000_00BE, 1'b0, "ld_byte1");
        for (int k = 1; k <= 4; k++) begin
            xact(1'b1, 2'b10, BASE + 32'(4 * k), 32'hA000_0000 + 32'(k), 32'd0, 1'b0, "pre_st");
        end

        // Backpressure: exactly RSP_DEPTH loads accepted, then ordered drain.
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            req_addr = BASE + 32'(4 * (acc + 1));
            if (req_ready) acc++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_ready_low", 32'(req_ready), 32'd0);
        chk("t3_valid_held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (rsp_valid) begin
                chk("t3_order", rsp_rdata, 32'hA000_0000 + 32'(got + 1));
                got++;
            end
            @(negedge clock);
        end
        chk("t3_count", 32'(got), 32'd4);
        chk("t3_drained", 32'(rsp_valid), 32'd0);

        // Reset with three responses pending; a store presented during reset is dropped.
        rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
        for (int k = 0; k < 3; k++) begin
            req_addr = BASE + 32'(4 * (k + 1));
            @(negedge clock);
        end
        chk("t4_pending", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        req_write = 1'b1; req_addr = BASE + 32'd4; req_wdata = 32'hFFFF_FFFF;
        #1;
        chk("t4_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t4_rst_ready", 32'(req_ready), 32'd0);
        chk("t4_rst_rdata", rsp_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        #1;
        chk("t4_flushed", 32'(rsp_valid), 32'd0);
        chk("t4_ready_back", 32'(req_ready), 32'd1);
        xact(1'b0, 2'b10, BASE + 32'd8, 32'd0, 32'hA000_0002, 1'b0, "t4_retained");
        xact(1'b0, 2'b10, BASE + 32'd4, 32'd0, 32'hA000_0001, 1'b0, "t4_rst_store_dropped");
        xact(1'b0, 2'b10, BASE, 32'd0, 32'h1234_BEEF, 1'b0, "t4_word0");

`ifdef DMEM_ERR_CHECK_EN
        xact(1'b0, 2'b10, BASE + 32'd2, 32'd0, 32'd0, 1'b1, "t5_misaligned");
        xact(1'b1, 2'b10, BASE + 32'(4 * DEPTH), 32'h5555_5555, 32'd0, 1'b1, "t5_oor_store");
        xact(1'b0, 2'b10, BASE, 32'd0, 32'h1234_BEEF, 1'b0, "t5_unchanged");
        xact(1'b0, 2'b00, BASE - 32'd1, 32'd0, 32'd0, 1'b1, "t5_below_base");
        xact(1'b0, 2'b11, BASE + 32'd4, 32'd0, 32'd0, 1'b1, "t5_size3");
`else
        xact(1'b0, 2'b10, BASE + 32'd2, 32'd0, 32'h1234_BEEF, 1'b0, "t5_align_down");
        xact(1'b1, 2'b01, BASE + 32'(4 * DEPTH) + 32'd2, 32'h0000_CAFE, 32'd0, 1'b0, "t5_wrap_store");
        xact(1'b0, 2'b10, BASE, 32'd0, 32'hCAFE_BEEF, 1'b0, "t5_wrap_load");
        xact(1'b0, 2'b11, BASE + 32'd4, 32'd0, 32'hA000_0001, 1'b0, "t5_size3_word");
`endif

        // rsp_ready toggling with a continuous stream: one pop every two cycles, in order.
        acc = 0; pops = 0; last = -1;
        req_write = 1'b0; req_size = 2'b10;
        for (int c = 0; c < 60 && pops < 8; c++) begin
            rsp_ready = (c % 2 == 1);
            req_valid = (acc < 8);
            req_addr  = BASE + 32'(4 * ((acc % 4) + 1));
            if (rsp_valid && rsp_ready) begin
                chk("t6_order", rsp_rdata, 32'hA000_0000 + 32'((pops % 4) + 1));
                if (pops > 0) chk("t6_spacing", 32'(c - last), 32'd2);
                last = c;
                pops++;
            end
            if (req_valid && req_ready) acc++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("t6_pops", 32'(pops), 32'd8);
        chk("t6_last_pop", 32'(last), 32'd15);
        @(negedge clock);
        chk("t6_idle", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
